// File: rtl/vedic_mul_pipe_if.sv
// Operand/result handshake bundle for vedic_mul_pipe.
// VEDIC_MUL_ACC_EN adds the in_acc/in_clr accumulate controls.
interface vedic_mul_pipe_if #(
   parameter int WIDTH = 8,
   parameter int TAG_W = 4
);
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   in_a;
   logic [WIDTH-1:0]   in_b;
   logic               in_signed;
   logic [TAG_W-1:0]   in_tag;
`ifdef VEDIC_MUL_ACC_EN
   logic               in_acc;
   logic               in_clr;
`endif
   logic               out_valid;
   logic               out_ready;
   logic [2*WIDTH-1:0] out_p;
   logic [TAG_W-1:0]   out_tag;

   modport master (
      output in_valid, in_a, in_b, in_signed, in_tag,
`ifdef VEDIC_MUL_ACC_EN
      output in_acc, in_clr,
`endif
      output out_ready,
      input  in_ready, out_valid, out_p, out_tag
   );

   modport slave (
      input  in_valid, in_a, in_b, in_signed, in_tag,
`ifdef VEDIC_MUL_ACC_EN
      input  in_acc, in_clr,
`endif
      input  out_ready,
      output in_ready, out_valid, out_p, out_tag
   );
endinterface

// File: rtl/vedic_mul_pipe.sv
// Two-stage pipelined Urdhva-split multiplier with signed/unsigned mode and valid/ready on both sides.
// Define VEDIC_MUL_ACC_EN to add a (2*WIDTH+8)-bit wrapping accumulator in stage 2.

// Recursive unsigned WxW Vedic core; splits down to 2x2 leaves.
module vedic_mul_core #(
   parameter int W = 2
) (
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic [2*W-1:0] p
);
   if (W == 2) begin : g_leaf
      logic t, u, v, c1;
      assign t    = a[1] & b[0];
      assign u    = a[0] & b[1];
      assign v    = a[1] & b[1];
      assign c1   = t & u;
      assign p[0] = a[0] & b[0];
      assign p[1] = t ^ u;
      assign p[2] = v ^ c1;
      assign p[3] = v & c1;
   end else begin : g_split
      localparam int H = W / 2;
      logic [W-1:0] hh, hl, lh, ll;
      vedic_mul_core #(.W(H)) u_hh (.a(a[W-1:H]), .b(b[W-1:H]), .p(hh));
      vedic_mul_core #(.W(H)) u_hl (.a(a[W-1:H]), .b(b[H-1:0]), .p(hl));
      vedic_mul_core #(.W(H)) u_lh (.a(a[H-1:0]), .b(b[W-1:H]), .p(lh));
      vedic_mul_core #(.W(H)) u_ll (.a(a[H-1:0]), .b(b[H-1:0]), .p(ll));
      assign p = ((2*W)'(hh) << W) + (((2*W)'(hl) + (2*W)'(lh)) << H) + (2*W)'(ll);
   end
endmodule

module vedic_mul_pipe #(
   parameter int WIDTH = 8,
   parameter int TAG_W = 4
) (
   input logic             clk,
   input logic             rst,
   vedic_mul_pipe_if.slave bus
);
   localparam int H = WIDTH / 2;
   localparam int P = 2 * WIDTH;

   logic             s1_valid;
   logic             s1_adv;
   logic             s2_adv;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic             neg_in;
   logic [WIDTH-1:0] hh, hl, lh, ll;

   logic [WIDTH-1:0] s1_hh, s1_hl, s1_lh, s1_ll;
   logic             s1_neg;
   logic [TAG_W-1:0] s1_tag;
   logic [P-1:0]     sum, prod;

`ifdef VEDIC_MUL_ACC_EN
   localparam int AW = P + 8;
   logic          s1_acc, s1_clr, s1_sgn;
   logic [AW-1:0] acc, acc_next;
`endif

   assign s2_adv       = !bus.out_valid || bus.out_ready;
   assign s1_adv       = !s1_valid || s2_adv;
   assign bus.in_ready = s1_adv;

   // The most negative operand maps to 2^(WIDTH-1), which still fits unsigned.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      a_mag  = bus.in_a;
      b_mag  = bus.in_b;
      neg_in = 1'b0;
      if (bus.in_signed) begin
         if (bus.in_a[WIDTH-1]) a_mag = ~bus.in_a + WIDTH'(1);
         if (bus.in_b[WIDTH-1]) b_mag = ~bus.in_b + WIDTH'(1);
         neg_in = bus.in_a[WIDTH-1] ^ bus.in_b[WIDTH-1];
      end
   end

   vedic_mul_core #(.W(H)) u_hh (.a(a_mag[WIDTH-1:H]), .b(b_mag[WIDTH-1:H]), .p(hh));
   vedic_mul_core #(.W(H)) u_hl (.a(a_mag[WIDTH-1:H]), .b(b_mag[H-1:0]),     .p(hl));
   vedic_mul_core #(.W(H)) u_lh (.a(a_mag[H-1:0]),     .b(b_mag[WIDTH-1:H]), .p(lh));
   vedic_mul_core #(.W(H)) u_ll (.a(a_mag[H-1:0]),     .b(b_mag[H-1:0]),     .p(ll));

   always_ff @(posedge clk) begin
      // NOTE: state is updated with <= so every register samples pre-edge values regardless of block order.
      if (rst) begin
         s1_valid <= 1'b0;
      end else if (s1_adv) begin
         s1_valid <= bus.in_valid;
         // NOTE: datapath registers carry no reset; s1_valid alone qualifies them.
         if (bus.in_valid) begin
            s1_hh  <= hh;
            s1_hl  <= hl;
            s1_lh  <= lh;
            s1_ll  <= ll;
            s1_neg <= neg_in;
            s1_tag <= bus.in_tag;
`ifdef VEDIC_MUL_ACC_EN
            s1_acc <= bus.in_acc;
            s1_clr <= bus.in_clr;
            s1_sgn <= bus.in_signed;
`endif
         end
      end
   end

   always_comb begin
      sum  = (P'(s1_hh) << WIDTH) + ((P'(s1_hl) + P'(s1_lh)) << H) + P'(s1_ll);
      prod = s1_neg ? (~sum + P'(1)) : sum;
`ifdef VEDIC_MUL_ACC_EN
      acc_next = (s1_clr ? '0 : acc) + {{8{s1_sgn & prod[P-1]}}, prod};
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.out_valid <= 1'b0;
         bus.out_p     <= '0;
         bus.out_tag   <= '0;
`ifdef VEDIC_MUL_ACC_EN
         acc           <= '0;
`endif
      end else if (s2_adv) begin
         bus.out_valid <= s1_valid;
         if (s1_valid) begin
            bus.out_tag <= s1_tag;
`ifdef VEDIC_MUL_ACC_EN
            if (s1_acc) begin
               acc       <= acc_next;
               bus.out_p <= acc_next[P-1:0];
            end else begin
               bus.out_p <= prod;
            end
`else
            bus.out_p <= prod;
`endif
         end
      end
   end
endmodule

// File: tb/tb_vedic_mul_pipe.sv
// Directed self-checking bench for vedic_mul_pipe (WIDTH=8, TAG_W=4); covers VEDIC_MUL_ACC_EN when defined.
module tb_vedic_mul_pipe;
   localparam int WIDTH = 8;
   localparam int TAG_W = 4;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   vedic_mul_pipe_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();
   vedic_mul_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (.clk(clk), .rst(rst), .bus(bus));

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                        input logic s, input logic [3:0] tag);
      bus.in_valid  = v;
      bus.in_a      = a;
      bus.in_b      = b;
      bus.in_signed = s;
      bus.in_tag    = tag;
   endtask

   // One isolated op with out_ready=1: result must appear exactly two edges after the transfer.
   task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic s, input logic [3:0] tag, input logic [15:0] exp);
      bus.out_ready = 1'b1;
      drive(1'b1, a, b, s, tag);
      tick();
      bus.in_valid = 1'b0;
      check({name, "_lat1"}, 64'(bus.out_valid), 64'd0);
      tick();
      check({name, "_valid"}, 64'(bus.out_valid), 64'd1);
      check({name, "_p"}, 64'(bus.out_p), 64'(exp));
      check({name, "_tag"}, 64'(bus.out_tag), 64'(tag));
   endtask

   initial begin
      int k;
      int j;
      rst = 1'b1;
      bus.out_ready = 1'b1;
      drive(1'b0, 8'h00, 8'h00, 1'b0, 4'h0);
`ifdef VEDIC_MUL_ACC_EN
      bus.in_acc = 1'b0;
      bus.in_clr = 1'b0;
`endif
      tick();
      tick();
      rst = 1'b0;
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_out_p", 64'(bus.out_p), 64'd0);
      check("rst_out_tag", 64'(bus.out_tag), 64'd0);
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);

      // Unsigned
      run_op("u_ff_ff", 8'hFF, 8'hFF, 1'b0, 4'h1, 16'hFE01);
      run_op("u_0f_10", 8'h0F, 8'h10, 1'b0, 4'h2, 16'h00F0);
      run_op("u_00_ab", 8'h00, 8'hAB, 1'b0, 4'h3, 16'h0000);
      // Signed
      run_op("s_m128_m128", 8'h80, 8'h80, 1'b1, 4'h4, 16'h4000);
      run_op("s_m128_1", 8'h80, 8'h01, 1'b1, 4'h5, 16'hFF80);
      run_op("s_m1_m1", 8'hFF, 8'hFF, 1'b1, 4'h6, 16'h0001);
      run_op("s_5_m3", 8'h05, 8'hFD, 1'b1, 4'h7, 16'hFFF1);
      run_op("s_0_m7", 8'h00, 8'hF9, 1'b1, 4'h8, 16'h0000);

      // Streaming: op c = c*3, tag c; result of op c-1 seen after edge c.
      for (int c = 0; c <= 16; c++) begin
         if (c < 16) drive(1'b1, 8'(c), 8'd3, 1'b0, 4'(c));
         else bus.in_valid = 1'b0;
         #1;
         if (c < 16) check("stream_in_ready", 64'(bus.in_ready), 64'd1);
         tick();
         if (c >= 1) begin
            check("stream_valid", 64'(bus.out_valid), 64'd1);
            check("stream_p", 64'(bus.out_p), 64'((c - 1) * 3));
            check("stream_tag", 64'(bus.out_tag), 64'(c - 1));
         end
      end
      tick();
      check("stream_drained", 64'(bus.out_valid), 64'd0);

      // Backpressure: op k = (20+k)*7, tag k.
      k = 0;
      for (int cyc = 0; cyc < 5; cyc++) begin
         bus.out_ready = 1'b0;
         drive(1'b1, 8'(20 + k), 8'd7, 1'b0, 4'(k));
         #1;
         if (bus.in_ready) k++;
         tick();
         if (cyc >= 1) begin
            check("stall_valid", 64'(bus.out_valid), 64'd1);
            check("stall_p", 64'(bus.out_p), 64'd140);
            check("stall_tag", 64'(bus.out_tag), 64'd0);
         end
      end
      check("stall_accepts", 64'(k), 64'd2);
      check("stall_in_ready", 64'(bus.in_ready), 64'd0);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      j = 0;
      for (int cyc = 0; cyc < 10; cyc++) begin
         if (bus.out_valid) begin
            check("drain_p", 64'(bus.out_p), 64'((20 + j) * 7));
            check("drain_tag", 64'(bus.out_tag), 64'(j));
            j++;
         end
         tick();
      end
      check("drain_count", 64'(j), 64'd2);

      // Reset with both stages full.
      bus.out_ready = 1'b0;
      drive(1'b1, 8'd9, 8'd9, 1'b0, 4'h5);
      tick();
      drive(1'b1, 8'd3, 8'd3, 1'b0, 4'h6);
      tick();
      bus.in_valid = 1'b0;
      check("full_valid", 64'(bus.out_valid), 64'd1);
      check("full_in_ready", 64'(bus.in_ready), 64'd0);
      rst = 1'b1;
      tick();
      check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
      check("mid_rst_p", 64'(bus.out_p), 64'd0);
      check("mid_rst_tag", 64'(bus.out_tag), 64'd0);
      rst = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
      check("post_rst_empty", 64'(bus.out_valid), 64'd0);
      run_op("post_rst", 8'd6, 8'd7, 1'b0, 4'h9, 16'd42);
      tick();
      check("post_rst_single", 64'(bus.out_valid), 64'd0);

`ifdef VEDIC_MUL_ACC_EN
      bus.in_acc = 1'b1;
      bus.in_clr = 1'b1;
      run_op("acc_3x4", 8'd3, 8'd4, 1'b1, 4'hA, 16'h000C);
      bus.in_clr = 1'b0;
      run_op("acc_5xm2", 8'd5, 8'hFE, 1'b1, 4'hB, 16'h0002);
      run_op("acc_1x1", 8'd1, 8'd1, 1'b1, 4'hC, 16'h0003);
      bus.in_acc = 1'b0;
      run_op("noacc_2x3", 8'd2, 8'd3, 1'b1, 4'hD, 16'h0006);
      bus.in_acc = 1'b1;
      run_op("acc_after_noacc", 8'd1, 8'd1, 1'b1, 4'hE, 16'h0004);
      bus.in_acc = 1'b0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/vedic_mul_pipe.md
Name: vedic_mul_pipe

Overview:
- Parametrised, pipelined Vedic (Urdhva-split) multiplier for the INT MAC datapath.
- Generalises the fixed 8x8 combinational Vedic multiplier to WIDTH x WIDTH.
- Adds per-transaction signed/unsigned mode, a 2-stage register pipeline and valid/ready handshakes on both sides so it can sit between operand FIFOs and the accumulator.

Parameters:
- WIDTH, 8, operand width. Power of two, >= 4. Product width is 2*WIDTH.
- TAG_W, 4, width of a user tag carried alongside each operation.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand transfer request.
- in_ready  out  1  block can accept operands this cycle.
- in_a  in  WIDTH  multiplicand.
- in_b  in  WIDTH  multiplier.
- in_signed  in  1  1 = operands are two's complement; 0 = unsigned.
- in_tag  in  TAG_W  opaque tag; returned unchanged with the result.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts the result.
- out_p  out  2*WIDTH  product.
- out_tag  out  TAG_W  tag of this product.

Behaviour:
- Transfers: input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
- Stage 1 (S1), registered on input transfer:
  - Signed mode: take magnitudes |a| and |b| (WIDTH-bit unsigned; the most negative value maps to 2^(WIDTH-1)). Store neg = a_msb ^ b_msb.
  - Unsigned mode: magnitudes are the raw operands; neg = 0.
  - Split each magnitude into hi and lo halves. Compute four (WIDTH/2)x(WIDTH/2) unsigned partial products hh, hl, lh, ll combinationally.
  - Register the partial products, neg, tag and s1_valid.
- Stage 2 (S2):
  - Sum = (hh << WIDTH) + ((hl + lh) << WIDTH/2) + ll, computed at 2*WIDTH bits. No overflow is possible.
  - If neg, store the two's complement of the sum; otherwise store the sum.
  - Register into out_p and out_tag, and set s2_valid = out_valid.
- Latency: exactly 2 cycles from input transfer to out_valid when there is no backpressure. Throughput: 1 operation per cycle.
- Ready logic:
  - s2_adv = !s2_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv.
  - in_ready is combinational from out_ready. This is acceptable; no skid buffer.
- Stall: while out_valid & !out_ready, out_p and out_tag hold stable. S1 holds if it is full, and in_ready drops when both stages are full.
- Bubbles: an empty S1 with s2_adv clears s2_valid. Results emerge strictly in input order.
- Simultaneous events: with a full pipe and out_ready = 1, a new input is accepted in the same cycle. No result is lost or duplicated.
- Zero operands: the product is 0 in either mode, with no negative zero (two's complement of 0 = 0).
- Reset: on rst, at the next clk edge s1_valid = 0, out_valid = 0, out_p = 0 and out_tag = 0. in_ready reads 1 in the cycle after reset. Operations in flight are discarded, and reset mid-stall drops the held result.
- Sub-multipliers: the hierarchy splits recursively down to 2x2 leaves via generate. Partial-product sums use plain + at full width.

Optional Feature:
- Macro: VEDIC_MUL_ACC_EN.
- When defined, the block adds:
  - Port in_acc (in, 1). When 1, the operation accumulates.
  - Port in_clr (in, 1). When 1, the accumulator is zeroed before this operation's product is added.
  - A 2*WIDTH+8 bit accumulator in S2, which wraps modulo 2^(2*WIDTH+8).
- Accumulating operations: acc <= (in_clr ? 0 : acc) + sign-extended product. out_p returns the low 2*WIDTH bits of the new acc.
- Non-accumulating operations: return the plain product and leave acc unchanged.
- The accumulator updates only on the S2 load cycle and resets to 0 with rst.
- When the macro is undefined, none of these ports or registers exist.

Test Plan:
- Unsigned products, WIDTH=8, out_ready=1: 0xFF*0xFF -> 0xFE01 at cycle +2; 0x0F*0x10 -> 0x00F0; 0*0xAB -> 0x0000.
- Signed products, WIDTH=8: -128*-128 -> 0x4000; -128*1 -> 0xFF80; -1*-1 -> 0x0001; 5*-3 -> 0xFFF1; 0*-7 -> 0x0000.
- Back-to-back streaming: 16 consecutive ops with tags 0..15 and out_ready=1 -> one result per cycle, in tag order, first at cycle +2.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready falls after 2 accepts and out_p/out_tag stay stable. Release out_ready -> no result lost or duplicated.
- Reset mid-operation: assert rst with both stages full -> next cycle out_valid=0 and out_p=0. A new op accepted after reset returns the correct product only.
- (VEDIC_MUL_ACC_EN) Sequence clr+acc 3*4, acc 5*-2, acc 1*1 -> out_p = 12, 2, 3 (0x000C, 0x0002, 0x0003).
